reg_file: RTL and testbench

Parametrised multi-port register file built from enable-gated word registers. It generalises the single 32-bit enabled register into DEPTH words with NUM_RD independent read ports and one write port. An optional hard-wired zero register and write-to-read bypass make it drop-in for the RISC-V integer register file (x0..x31) in the decode stage.

---
 rtl/reg_file_pkg.sv | 10 +
 rtl/reg_nb.sv | 23 ++
 rtl/reg_file.sv | 71 +++++++
 tb/tb_reg_file.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the integer register file.
package reg_file_pkg;

    localparam int XLEN          = 32;
    localparam int NUM_ARCH_REGS = 32;

    typedef logic [4:0]      reg_addr_t;
    typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/reg_nb.sv
// Single storage word: WIDTH-bit register with load enable and async active-low clear.
module reg_nb
    import reg_file_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear immediately on reset, otherwise load d when enabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Multi-port register file: one write port, NUM_RD combinational read ports,
// optional hard-wired zero word and same-cycle write-to-read forwarding.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = XLEN,
    parameter int DEPTH    = NUM_ARCH_REGS,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [AW-1:0]                  waddr,
    input  logic [WIDTH-1:0]               wdata,
    input  logic [NUM_RD-1:0][AW-1:0]      raddr,
    output logic [NUM_RD-1:0][WIDTH-1:0]   rdata
);

    // Word 0 has no storage behind it when it is the hard-wired zero register
    localparam int FIRST = (ZERO_REG != 0) ? 1 : 0;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             waddr_ok;

    // Addresses at or beyond DEPTH exist only for non-power-of-two depths
    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(DEPTH));
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign waddr_ok = in_range(waddr);

    genvar k;
    for (k = 0; k < DEPTH; k++) begin : g_word
        if (k < FIRST) begin : g_zero
            assign mem[k] = '0;
        end else begin : g_reg
            logic en;
            assign en = we & waddr_ok & (waddr == AW'(k));
            reg_nb #(.WIDTH(WIDTH)) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (en),
                .d     (wdata),
                .q     (mem[k])
            );
        end
    end

    // Per-port read: zero during reset, for x0 and for out-of-range addresses;
    // otherwise forwarded write data on an address match, else the stored word
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rdata[i] = '0;
            if (reset && in_range(raddr[i]) && !is_zero_reg(raddr[i])) begin
                if ((BYPASS != 0) && we && (waddr == raddr[i])) begin
                    rdata[i] = wdata;
                end else begin
                    rdata[i] = mem[raddr[i]];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: default RISC-V configuration, a no-bypass
// instance and a 24-deep three-port instance.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk;
    logic reset;

    // Default configuration (BYPASS=1, ZERO_REG=1, 32x32, 2 ports)
    logic                 we_m;
    logic [4:0]           wa_m;
    word_t                wd_m;
    logic [1:0][4:0]      ra_m;
    logic [1:0][31:0]     rd_m;

    // No-bypass configuration
    logic                 we_n;
    logic [4:0]           wa_n;
    word_t                wd_n;
    logic [1:0][4:0]      ra_n;
    logic [1:0][31:0]     rd_n;

    // DEPTH=24, NUM_RD=3
    logic                 we_d;
    logic [4:0]           wa_d;
    word_t                wd_d;
    logic [2:0][4:0]      ra_d;
    logic [2:0][31:0]     rd_d;

    reg_file u_main (
        .clk   (clk),
        .reset (reset),
        .we    (we_m),
        .waddr (wa_m),
        .wdata (wd_m),
        .raddr (ra_m),
        .rdata (rd_m)
    );

    reg_file #(.BYPASS(0)) u_nb (
        .clk   (clk),
        .reset (reset),
        .we    (we_n),
        .waddr (wa_n),
        .wdata (wd_n),
        .raddr (ra_n),
        .rdata (rd_n)
    );

    reg_file #(.DEPTH(24), .NUM_RD(3)) u_d24 (
        .clk   (clk),
        .reset (reset),
        .we    (we_d),
        .waddr (wa_d),
        .wdata (wd_d),
        .raddr (ra_d),
        .rdata (rd_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    logic [31:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mkv(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] r0, input logic [4:0] r1,
                                 input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.ra0 = r0; v.ra1 = r1; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic push_exp(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string nm, input logic [31:0] act);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got %h", nm, act);
        end else begin
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s: got %h expected %h", nm, act, e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mkv(1'b1, 5'd5,  32'h1234_5678, 5'd5, 5'd31, 32'h1234_5678, 32'h0);
        vecs[1]  = mkv(1'b1, 5'd31, 32'hDEAD_BEEF, 5'd5, 5'd31, 32'h1234_5678, 32'hDEAD_BEEF);
        vecs[2]  = mkv(1'b0, 5'd0,  32'h0,         5'd5, 5'd31, 32'h1234_5678, 32'hDEAD_BEEF);
        vecs[3]  = mkv(1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0, 5'd0,  32'h0,         32'h0);
        vecs[4]  = mkv(1'b0, 5'd0,  32'hFFFF_FFFF, 5'd0, 5'd5,  32'h0,         32'h1234_5678);
        vecs[5]  = mkv(1'b1, 5'd7,  32'hAAAA_AAAA, 5'd1, 5'd2,  32'h0,         32'h0);
        vecs[6]  = mkv(1'b1, 5'd7,  32'h5555_5555, 5'd7, 5'd7,  32'h5555_5555, 32'h5555_5555);
        vecs[7]  = mkv(1'b0, 5'd7,  32'h0BAD_F00D, 5'd7, 5'd7,  32'h5555_5555, 32'h5555_5555);
        vecs[8]  = mkv(1'b0, 5'd7,  32'h0BAD_F00D, 5'd7, 5'd31, 32'h5555_5555, 32'hDEAD_BEEF);
        vecs[9]  = mkv(1'b1, 5'd9,  32'hCAFE_BABE, 5'd9, 5'd8,  32'hCAFE_BABE, 32'h0);
        vecs[10] = mkv(1'b0, 5'd9,  32'h0,         5'd9, 5'd9,  32'hCAFE_BABE, 32'hCAFE_BABE);
        vecs[11] = mkv(1'b1, 5'd8,  32'h0000_0808, 5'd9, 5'd5,  32'hCAFE_BABE, 32'h1234_5678);

        reset = 1'b0;
        we_m = 1'b1; wa_m = 5'd3; wd_m = 32'hFFFF_FFFF; ra_m[0] = 5'd3; ra_m[1] = 5'd3;
        we_n = 1'b0; wa_n = '0; wd_n = '0; ra_n = '0;
        we_d = 1'b0; wa_d = '0; wd_d = '0; ra_d = '0;

        // Reset held across two edges with a write pending: bypass suppressed, nothing stored
        @(negedge clk);
        #2;
        push_exp(32'h0); check("rst_bypass_p0", rd_m[0]);
        push_exp(32'h0); check("rst_bypass_p1", rd_m[1]);
        @(negedge clk);
        we_m = 1'b0;
        reset = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            ra_m[0] = 5'(a);
            ra_m[1] = 5'(31 - a);
            push_exp(32'h0);
            push_exp(32'h0);
            #1;
            check($sformatf("rst_clear_p0_a%0d", a), rd_m[0]);
            check($sformatf("rst_clear_p1_a%0d", 31 - a), rd_m[1]);
        end

        // Table-driven vectors: expected values observed before the edge
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            we_m = vecs[i].we; wa_m = vecs[i].wa; wd_m = vecs[i].wd;
            ra_m[0] = vecs[i].ra0; ra_m[1] = vecs[i].ra1;
            push_exp(vecs[i].e0);
            push_exp(vecs[i].e1);
            #2;
            check($sformatf("vec%0d_p0", i), rd_m[0]);
            check($sformatf("vec%0d_p1", i), rd_m[1]);
        end

        // Reset mid-cycle with a write pending on addr 9
        @(negedge clk);
        we_m = 1'b1; wa_m = 5'd9; wd_m = 32'hCAFE_BABE; ra_m[0] = 5'd9; ra_m[1] = 5'd5;
        #2;
        reset = 1'b0;
        #1;
        push_exp(32'h0); check("midrst_a9", rd_m[0]);
        push_exp(32'h0); check("midrst_a5", rd_m[1]);
        we_m = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        push_exp(32'h0); check("postrst_a9", rd_m[0]);
        push_exp(32'h0); check("postrst_a5", rd_m[1]);

        // No-bypass instance: old value until the edge, then new value; we=0 holds
        @(negedge clk);
        we_n = 1'b1; wa_n = 5'd7; wd_n = 32'hAAAA_AAAA; ra_n[0] = 5'd7; ra_n[1] = 5'd7;
        #2;
        push_exp(32'h0); check("nb_first_p0", rd_n[0]);
        @(negedge clk);
        wd_n = 32'h5555_5555;
        #2;
        push_exp(32'hAAAA_AAAA); check("nb_before_p0", rd_n[0]);
        push_exp(32'hAAAA_AAAA); check("nb_before_p1", rd_n[1]);
        @(posedge clk);
        #1;
        push_exp(32'h5555_5555); check("nb_after_p0", rd_n[0]);
        push_exp(32'h5555_5555); check("nb_after_p1", rd_n[1]);
        @(negedge clk);
        we_n = 1'b0; wd_n = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        push_exp(32'h5555_5555); check("nb_hold_p0", rd_n[0]);
        ra_n[0] = 5'd0; ra_n[1] = 5'd6;
        #1;
        push_exp(32'h0); check("nb_x0", rd_n[0]);
        push_exp(32'h0); check("nb_a6", rd_n[1]);

        // 24-deep instance: out-of-range write ignored, out-of-range read is zero
        @(negedge clk);
        we_d = 1'b1; wa_d = 5'd30; wd_d = 32'h1111_1111;
        ra_d[0] = 5'd30; ra_d[1] = 5'd23; ra_d[2] = 5'd6;
        #2;
        push_exp(32'h0); check("d24_oor_byp_p0", rd_d[0]);
        push_exp(32'h0); check("d24_oor_byp_p1", rd_d[1]);
        push_exp(32'h0); check("d24_oor_byp_p2", rd_d[2]);
        @(posedge clk);
        #1;
        we_d = 1'b0;
        for (int a = 0; a < 24; a++) begin
            ra_d[0] = 5'(a); ra_d[1] = 5'd30; ra_d[2] = 5'd31;
            push_exp(32'h0);
            #1;
            check($sformatf("d24_nochange_a%0d", a), rd_d[0]);
        end
        push_exp(32'h0); check("d24_rd30", rd_d[1]);
        push_exp(32'h0); check("d24_rd31", rd_d[2]);

        @(negedge clk);
        we_d = 1'b1; wa_d = 5'd23; wd_d = 32'h2323_2323;
        ra_d[0] = 5'd23; ra_d[1] = 5'd23; ra_d[2] = 5'd23;
        #2;
        for (int p = 0; p < 3; p++) begin
            push_exp(32'h2323_2323);
            check($sformatf("d24_a23_byp_p%0d", p), rd_d[p]);
        end
        @(negedge clk);
        we_d = 1'b1; wa_d = 5'd22; wd_d = 32'h2222_2222;
        ra_d[0] = 5'd23; ra_d[1] = 5'd23; ra_d[2] = 5'd23;
        #2;
        for (int p = 0; p < 3; p++) begin
            push_exp(32'h2323_2323);
            check($sformatf("d24_a23_stored_p%0d", p), rd_d[p]);
        end
        @(negedge clk);
        we_d = 1'b0;
        ra_d[0] = 5'd22; ra_d[1] = 5'd23; ra_d[2] = 5'd24;
        #2;
        push_exp(32'h2222_2222); check("d24_a22", rd_d[0]);
        push_exp(32'h2323_2323); check("d24_a23", rd_d[1]);
        push_exp(32'h0);         check("d24_a24", rd_d[2]);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
